// File: rtl/foc_pkg.sv
// foc_pkg: Fibonacci weight table, code width helper and per-segment FOC encode/decode.
//   FIB        weights w0..w9 = 1,2,3,5,8,...
//   cw_of      code bits needed for a SEG-bit segment
//   seg_enc    greedy Zeckendorf encode of one segment value
//   seg_dec    weighted sum of the set bits of one code segment
package foc_pkg;
  localparam int MAXCW = 10;
  localparam int FIB [MAXCW] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
  // Smallest n whose next weight exceeds every SEG-bit value, so n weights reach 2^seg-1.
  function automatic int cw_of(input int seg);
    int n;
    n = MAXCW;
    for (int i = MAXCW - 1; i >= 0; i--)
      if (FIB[i] >= (1 << seg)) n = i;
    return n;
  endfunction
  function automatic logic [MAXCW-1:0] seg_enc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    seg_enc = '0;
    for (int i = MAXCW - 1; i >= 0; i--)
      if (int'(r) >= FIB[i]) begin
        seg_enc[i] = 1'b1;
        r = r - 8'(FIB[i]);
      end
  endfunction
  function automatic logic [7:0] seg_dec(input logic [MAXCW-1:0] c);
    seg_dec = '0;
    for (int i = 0; i < MAXCW; i++)
      if (c[i]) seg_dec = seg_dec + 8'(FIB[i]);
  endfunction
endpackage

// File: rtl/foc_seg_dec.sv
// foc_seg_dec: decode one CW-bit code segment into SEG data bits plus an illegal flag.
//   code     received code segment (after fault mask)
//   byp      segment travelled raw; take low bits, no legality check
//   data     decoded segment value (low SEG bits of the weight sum)
//   illegal  adjacent ones or sum above 2^SEG-1
module foc_seg_dec import foc_pkg::*; #(
  parameter int SEG = 4,
  parameter int CW = 6
) (
  input  logic [CW-1:0]  code,
  input  logic           byp,
  output logic [SEG-1:0] data,
  output logic           illegal
);
  logic [7:0] sum;
  logic adj;
  assign sum = seg_dec(MAXCW'(code));
  assign adj = |(code[CW-2:0] & code[CW-1:1]);
  assign data = byp ? code[SEG-1:0] : sum[SEG-1:0];
  assign illegal = !byp && (adj || sum > 8'((1 << SEG) - 1));
endmodule

// File: rtl/foc_pipe_codec.sv
// foc_pipe_codec: three-stage FOC encode -> bus -> decode pipeline with backpressure.
//   clk, rst        clock; asynchronous active-low reset
//   bypass          sampled per word: raw zero-padded segments instead of FOC code
//   in_valid/ready  upstream handshake, data_in word
//   bus_flip        fault mask XORed onto the bus at the decoder input
//   bus_out         registered bus codeword (S2)
//   out_valid/ready downstream handshake, data_out word, dec_err flag
//   err_cnt         saturating count of delivered words with dec_err
module foc_pipe_codec import foc_pkg::*; #(
  parameter int DW = 32,
  parameter int SEG = 4,
  parameter int CW = 6,
  localparam int NSEG = DW / SEG,
  localparam int BW = NSEG * CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bypass,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  input  logic [BW-1:0] bus_flip,
  output logic [BW-1:0] bus_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic          dec_err,
  output logic [15:0]   err_cnt
);
  logic en, v1, b1, v2, b2;
  logic [DW-1:0] d1, dec;
  logic [BW-1:0] enc, bus_in;
  logic [NSEG-1:0] ill;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign bus_in = bus_out ^ bus_flip;
  for (genvar i = 0; i < NSEG; i++) begin : g_seg
    assign enc[i*CW +: CW] = b1 ? CW'(d1[i*SEG +: SEG]) : CW'(seg_enc(8'(d1[i*SEG +: SEG])));
    foc_seg_dec #(.SEG(SEG), .CW(CW)) u_dec (
      .code(bus_in[i*CW +: CW]),
      .byp(b2),
      .data(dec[i*SEG +: SEG]),
      .illegal(ill[i])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      b1 <= 1'b0;
      d1 <= '0;
      v2 <= 1'b0;
      b2 <= 1'b0;
      bus_out <= '0;
      out_valid <= 1'b0;
      data_out <= '0;
      dec_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (en) begin
        v1 <= in_valid;
        d1 <= data_in;
        b1 <= bypass;
        v2 <= v1;
        b2 <= b1;
        bus_out <= enc;
        out_valid <= v2;
        data_out <= dec;
        dec_err <= v2 && |ill;
      end
      if (out_valid && out_ready && dec_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
endmodule
